// File: rtl/rtl_sequencer.sv
// SAR ADC conversion sequencer: drives init/sample/compare/update strobes to the digital core
// and assembles the comparator decisions MSB-first into the result word.
module rtl_sequencer #(
  parameter int unsigned NBITS = 16,
  parameter int unsigned SAMPW = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [SAMPW-1:0] samp_cycles,
  input  logic [4:0]       conv_bits,
  input  logic             comp_out,
  output logic             seq_init,
  output logic             seq_samp,
  output logic             seq_comp,
  output logic             seq_update,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] result
);

  typedef enum logic [2:0] {StIdle, StInit, StSamp, StComp, StUpdate, StDone} state_e;

  state_e           state_q;
  logic [SAMPW-1:0] samp_len_q;
  logic [SAMPW-1:0] samp_cnt_q;
  logic [4:0]       bits_q;
  logic [4:0]       dec_cnt_q;
  logic [NBITS-1:0] shift_q;

  logic [SAMPW-1:0] samp_len_eff;
  logic [4:0]       bits_eff;
  logic [NBITS-1:0] shift_nxt;
  logic [4:0]       dec_cnt_nxt;

  // Clamp the requested configuration to the range the sequencer can execute.
  always_comb begin
    samp_len_eff = (samp_cycles == '0) ? SAMPW'(1) : samp_cycles;
    if (conv_bits == 5'd0) begin
      bits_eff = 5'd1;
    end else if (32'(conv_bits) > NBITS) begin
      bits_eff = 5'(NBITS);
    end else begin
      bits_eff = conv_bits;
    end
    shift_nxt   = {shift_q[NBITS-2:0], comp_out};
    dec_cnt_nxt = dec_cnt_q + 5'd1;
  end

  // Outputs are registered: each transition also sets the strobes for the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= StIdle;
      samp_len_q <= '0;
      samp_cnt_q <= '0;
      bits_q     <= '0;
      dec_cnt_q  <= '0;
      shift_q    <= '0;
      result     <= '0;
      seq_init   <= 1'b0;
      seq_samp   <= 1'b0;
      seq_comp   <= 1'b0;
      seq_update <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      seq_init   <= 1'b0;
      seq_samp   <= 1'b0;
      seq_comp   <= 1'b0;
      seq_update <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StInit;
            seq_init   <= 1'b1;
            busy       <= 1'b1;
            samp_len_q <= samp_len_eff;
            bits_q     <= bits_eff;
            shift_q    <= '0;
            dec_cnt_q  <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        StInit: begin
          state_q    <= StSamp;
          seq_samp   <= 1'b1;
          busy       <= 1'b1;
          samp_cnt_q <= SAMPW'(1);
        end
        StSamp: begin
          busy <= 1'b1;
          if (samp_cnt_q == samp_len_q) begin
            state_q  <= StComp;
            seq_comp <= 1'b1;
          end else begin
            samp_cnt_q <= samp_cnt_q + SAMPW'(1);
            seq_samp   <= 1'b1;
          end
        end
        StComp: begin
          state_q    <= StUpdate;
          seq_update <= 1'b1;
          busy       <= 1'b1;
        end
        StUpdate: begin
          shift_q   <= shift_nxt;
          dec_cnt_q <= dec_cnt_nxt;
          if (dec_cnt_nxt == bits_q) begin
            state_q <= StDone;
            done    <= 1'b1;
            result  <= shift_nxt;
          end else begin
            state_q  <= StComp;
            seq_comp <= 1'b1;
            busy     <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rtl_sequencer.sv
// Scoreboard bench for rtl_sequencer: expected result, done cycle and phase lengths are queued
// per accepted start and compared when done pulses.
module tb_rtl_sequencer;
  localparam int unsigned NBITS = 16;
  localparam int unsigned SAMPW = 8;

  logic             clk = 1'b0;
  logic             rst_b = 1'b0;
  logic             start = 1'b0;
  logic [SAMPW-1:0] samp_cycles = '0;
  logic [4:0]       conv_bits = '0;
  logic             comp_out = 1'b0;
  logic             seq_init, seq_samp, seq_comp, seq_update, busy, done;
  logic [NBITS-1:0] result;

  rtl_sequencer #(.NBITS(NBITS), .SAMPW(SAMPW)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .start      (start),
    .samp_cycles(samp_cycles),
    .conv_bits  (conv_bits),
    .comp_out   (comp_out),
    .seq_init   (seq_init),
    .seq_samp   (seq_samp),
    .seq_comp   (seq_comp),
    .seq_update (seq_update),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [NBITS-1:0] res;
    int unsigned      done_cyc;
    int unsigned      s;
    int unsigned      b;
  } exp_t;

  exp_t             sb[$];
  logic [NBITS-1:0] cur_pat = '0;
  int unsigned      cur_b = 1;
  int unsigned      n_samp = 0, n_upd = 0, n_init = 0;
  logic             done_prev = 1'b0;

  // Monitor: invariants every cycle, comparator stimulus on update, scoreboard pop on done.
  always @(negedge clk) begin
    check("onehot", 32'($countones({seq_init, seq_samp, seq_comp, seq_update}) <= 1), 32'd1);
    check("busy", 32'(busy), 32'(seq_init | seq_samp | seq_comp | seq_update));
    check("done_twice", 32'(done & done_prev), 32'd0);
    if (seq_init) begin
      n_init = 1; n_samp = 0; n_upd = 0;
    end
    if (seq_samp) n_samp++;
    if (seq_update) begin
      comp_out = (n_upd < cur_b) ? cur_pat[cur_b-1-n_upd] : 1'($urandom);
      n_upd++;
    end
    if (done) begin
      if (sb.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("latency", cyc, e.done_cyc);
        check("samp_len", n_samp, e.s);
        check("decisions", n_upd, e.b);
        check("init_len", n_init, 1);
      end
      n_init = 0;
    end
    done_prev = done;
  end

  function automatic exp_t make_exp(input int unsigned s_in, input int unsigned b_in,
                                    input logic [NBITS-1:0] pat, input int unsigned acc);
    exp_t        e;
    logic [31:0] mask;
    e.s      = (s_in == 0) ? 1 : s_in;
    e.b      = (b_in == 0) ? 1 : ((b_in > NBITS) ? NBITS : b_in);
    mask     = (32'h1 << e.b) - 32'h1;
    e.res    = NBITS'(32'(pat) & mask);
    e.done_cyc = acc + 1 + e.s + 2 * e.b;
    return e;
  endfunction

  // Issue one start; returns just after the accepting edge with start still high.
  task automatic issue(input int unsigned s_in, input int unsigned b_in,
                       input logic [NBITS-1:0] pat, output int unsigned acc);
    exp_t e;
    @(negedge clk);
    samp_cycles = SAMPW'(s_in);
    conv_bits   = 5'(b_in);
    e           = make_exp(s_in, b_in, pat, 0);
    cur_pat     = pat;
    cur_b       = e.b;
    start       = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    sb.push_back(make_exp(s_in, b_in, pat, acc));
  endtask

  task automatic conv(input int unsigned s_in, input int unsigned b_in,
                      input logic [NBITS-1:0] pat);
    int unsigned acc;
    issue(s_in, b_in, pat, acc);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || busy || done) && n < 2000);
    if (n >= 2000) check("timeout_idle", 32'd1, 32'd0);
  endtask

  task automatic wait_sig(input int which);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((which == 0) ? seq_samp : seq_comp) && n < 500);
    if (n >= 500) check("timeout_strobe", 32'd1, 32'd0);
  endtask

  initial begin
    int unsigned acc, p, k;
    // Reset with start high: nothing may happen.
    start = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_strobes", 32'({seq_init, seq_samp, seq_comp, seq_update}), 32'd0);
    check("rst_busy_done", 32'({busy, done}), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    start = 1'b0;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Basic conversion, then hold check.
    conv(3, 4, 16'h000B);
    wait_idle();
    repeat (3) @(negedge clk);
    check("result_hold", 32'(result), 32'h000B);

    // Clamping.
    conv(0, 0, 16'h0001);
    wait_idle();
    conv(0, 31, 16'hFFFF);
    wait_idle();
    conv(2, 20, 16'hA5C3);
    wait_idle();
    conv(1, 1, 16'h0000);
    wait_idle();

    // Random configurations.
    for (int i = 0; i < 4; i++) begin
      conv($urandom_range(1, 6), $urandom_range(1, 16), NBITS'($urandom));
      wait_idle();
    end

    // Back-to-back with start held high for three conversions.
    issue(2, 3, 16'h0005, acc);
    p = 2 + 2 + 2 * 3;
    sb.push_back(make_exp(2, 3, 16'h0005, acc + p));
    sb.push_back(make_exp(2, 3, 16'h0005, acc + 2 * p));
    do @(negedge clk); while (cyc < acc + 2 * p);
    start = 1'b0;
    wait_idle();

    // Start pulses and config changes mid-conversion are ignored.
    conv(4, 5, 16'h0016);
    wait_sig(0);
    start = 1'b1; conv_bits = 5'd2; samp_cycles = 8'd1;
    @(negedge clk);
    start = 1'b0;
    wait_sig(1);
    start = 1'b1; conv_bits = 5'd9;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset during the third update aborts cleanly.
    conv(2, 6, 16'h002D);
    k = 0;
    for (int n = 0; n < 200 && k < 3; n++) begin
      @(negedge clk);
      if (seq_update) k++;
    end
    check("saw_third_update", k, 3);
    rst_b = 1'b0;
    @(negedge clk);
    check("abort_strobes", 32'({seq_init, seq_samp, seq_comp, seq_update}), 32'd0);
    check("abort_busy_done", 32'({busy, done}), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    sb.delete();
    rst_b = 1'b1;
    conv(1, 8, 16'h00C9);
    wait_idle();
    check("post_reset_result", 32'(result), 32'h00C9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
